// File: rtl/uart_rx_fifo.sv
// UART receiver with a small receive FIFO.
//
// Serial frames on rxd are oversampled by a half-bit timer, then checked for
// parity and stop-bit errors. Each completed frame is queued as
// {ferr, perr, data} whether or not it carries errors.
//
// Ports:
//   clk      single clock, all logic on posedge
//   rst      synchronous active-high reset
//   rxd      asynchronous serial input, idle high
//   rdata    FIFO head data (0 when empty)
//   rvalid   FIFO non-empty
//   rready   pop request, honoured when rvalid is high
//   perr     parity error flag of the head entry
//   ferr     frame (stop-bit) error flag of the head entry
//   overrun  one-cycle pulse when a completed frame is dropped
//   level    current FIFO occupancy
//
// state        | meaning
// S_IDLE       | line idle, waiting for a falling edge
// S_START      | timing to the middle of the start bit
// S_DATA       | sampling data bits, LSB first
// S_PARITY     | sampling the parity bit
// S_STOP       | sampling stop bit(s)
// S_BREAK_WAIT | framing error seen, waiting for the line to go high
module uart_rx_fifo #(
  parameter int CLK_PER_HALF_BIT = 391,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic                          perr,
  output logic                          ferr,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int TW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           sync_q, sync_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_bit_q, perr_bit_d;
  logic                 ferr_bit_q, ferr_bit_d;
  logic                 push_q, push_d;
  logic [EW-1:0]        frame_q, frame_d;

  logic                 rx;
  logic                 sample;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 pop;
  logic                 full;
  logic                 accept;
  logic [EW-1:0]        head;

  assign sync_d = {sync_q[1:0], rxd};
  assign rx     = sync_q[2];

  // State register and receiver datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync_q     <= 3'b111;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      perr_bit_q <= 1'b0;
      ferr_bit_q <= 1'b0;
      push_q     <= 1'b0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      perr_bit_q <= perr_bit_d;
      ferr_bit_q <= ferr_bit_d;
      push_q     <= push_d;
      frame_q    <= frame_d;
    end
  end

  // Sample strobe: mid start bit after a half bit, then every full bit.
  always_comb begin
    sample = 1'b0;
    case (state_q)
      S_START:                  sample = (timer_q == TW'(CLK_PER_HALF_BIT - 1));
      S_DATA, S_PARITY, S_STOP: sample = (timer_q == TW'(2 * CLK_PER_HALF_BIT - 1));
      default:                  sample = 1'b0;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    perr_bit_d = perr_bit_q;
    ferr_bit_d = ferr_bit_q;
    push_d     = 1'b0;
    frame_d    = frame_q;
    if (sample) timer_d = '0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx) state_d = S_START;
      end
      S_START: begin
        if (sample) begin
          if (!rx) begin
            state_d    = S_DATA;
            bit_cnt_d  = '0;
            perr_bit_d = 1'b0;
            ferr_bit_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          data_d    = {rx, data_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          // Odd parity expects a total XOR of 1, even parity expects 0.
          perr_bit_d = ((^data_q) ^ rx) != (PARITY == 1);
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          ferr_bit_d = ferr_bit_q | ~rx;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            push_d    = 1'b1;
            frame_d   = {ferr_bit_d, perr_bit_q, data_q};
            state_d   = ferr_bit_d ? S_BREAK_WAIT : S_IDLE;
          end
        end
      end
      S_BREAK_WAIT: begin
        timer_d = '0;
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receive FIFO
  assign rvalid  = (level_q != '0);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop     = rvalid && rready;
  // A pop in the same cycle frees the slot the push needs.
  assign accept  = push_q && (!full || pop);
  assign overrun = push_q && !accept;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_ptr_q] <= frame_q;
  end

  assign rdata = rvalid ? head[DATA_BITS-1:0] : '0;
  assign perr  = rvalid & head[DATA_BITS];
  assign ferr  = rvalid & head[DATA_BITS+1];
  assign level = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int H     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rready;
  logic [7:0] rdata;
  logic       rvalid, perr, ferr, overrun;
  logic [2:0] level;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .perr(perr), .ferr(ferr), .overrun(overrun), .level(level)
  );

  int total = 0;
  int bad   = 0;
  int ovr_seen = 0;
  int ovr_exp  = 0;
  logic [9:0] model_q [$];   // {ferr, perr, data}

  always @(negedge clk) if (overrun === 1'b1) ovr_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame: start, 8 data LSB first, even-parity bit, one stop bit.
  // Optionally holds the line low afterwards to emulate a break.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input int low_after);
    logic [10:0] bits;
    bits = {sbit, pbit, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rxd = bits[i];
      repeat (2 * H) @(negedge clk);
    end
    if (low_after > 0) begin
      rxd = 1'b0;
      repeat (low_after) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (2 * H) @(negedge clk);
    if (model_q.size() < DEPTH) model_q.push_back({~sbit, (^d) ^ pbit, d});
    else ovr_exp++;
  endtask

  task automatic check_head(input string tag);
    check({tag, "_rvalid"}, rvalid, model_q.size() != 0);
    check({tag, "_level"}, level, model_q.size());
    if (model_q.size() != 0) begin
      check({tag, "_rdata"}, rdata, model_q[0][7:0]);
      check({tag, "_perr"}, perr, model_q[0][8]);
      check({tag, "_ferr"}, ferr, model_q[0][9]);
    end
  endtask

  task automatic pop_one(input string tag);
    check_head(tag);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  initial begin
    logic [7:0] d;
    logic       p;

    rst = 1'b1; rxd = 1'b1; rready = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_rvalid", rvalid, 0);
    check("rst_level", level, 0);
    check("rst_rdata", rdata, 0);
    check("rst_perr", perr, 0);
    check("rst_ferr", ferr, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean frame, then pop to empty.
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check_head("a5");
    pop_one("a5_pop");
    check_head("a5_empty");

    // 0x07 has three ones: parity bit 0 is an error, 1 is correct.
    send_frame(8'h07, 1'b0, 1'b1, 0);
    pop_one("p07_bad");
    send_frame(8'h07, 1'b1, 1'b1, 0);
    pop_one("p07_good");

    // Short low glitch must not start a frame.
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (24) @(negedge clk);
    check_head("glitch");

    // Pop with nothing queued is ignored.
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check_head("empty_pop");

    // Stop bit 0 followed by a held-low line: one ferr entry and nothing more.
    send_frame(8'h5A, 1'b0, 1'b0, 40);
    repeat (100) @(negedge clk);
    check_head("break");
    pop_one("break_pop");
    send_frame(8'hC3, 1'b0, 1'b1, 0);
    pop_one("after_break");

    // Random frames, some with deliberate parity errors.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, p, 1'b1, 0);
      pop_one("rand");
    end
    check_head("rand_empty");

    // Five frames with no pop into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(d, ^d, 1'b1, 0);
    end
    check_head("full");
    check("overrun_count", ovr_seen, ovr_exp);
    for (int i = 0; i < 4; i++) pop_one("full_drain");
    check_head("full_empty");

    // Reset in the middle of a frame with one frame already queued.
    send_frame(8'h11, 1'b0, 1'b1, 0);
    check_head("pre_rst");
    rxd = 1'b0;
    repeat (2 * H) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * H) @(negedge clk);
    rxd = 1'b0;
    repeat (2 * H) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    model_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_head("post_rst");
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    pop_one("post_rst_3c");
    check_head("final");
    check("overrun_final", ovr_seen, ovr_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 391, meaning clk cycles per half UART bit (>=2).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..8).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none / 1 odd / 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of 2, >=2).
REQ-006 SHALL have clk  input  1  single clock; all logic on posedge.
REQ-007 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have rxd  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have rdata  output  DATA_BITS  FIFO head data.
REQ-010 SHALL have rvalid  output  1  FIFO non-empty.
REQ-011 SHALL have rready  input  1  consumer pops head when rvalid&&rready.
REQ-012 SHALL have perr  output  1  parity error flag of head entry (0 when PARITY=0).
REQ-013 SHALL have ferr  output  1  frame (stop-bit) error flag of head entry.
REQ-014 SHALL have overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL pass rxd through a 3-flop synchronizer reset to all-ones; "rx" below means its last stage.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-018 IDLE: rx==0 -> START, bit-timer cleared.
REQ-019 START: at timer == CLK_PER_HALF_BIT-1 sample rx; 0 -> DATA, 1 -> IDLE (glitch rejected, nothing pushed).
REQ-020 Every later sample SHALL occur exactly 2*CLK_PER_HALF_BIT cycles after the previous sample.
REQ-021 DATA: DATA_BITS samples, LSB first; then PARITY if PARITY!=0, else STOP.
REQ-022 PARITY: one sample; perr=1 if (XOR of data bits ^ sample) != (PARITY==1 ? 1 : 0).
REQ-023 STOP: STOP_BITS samples; ferr=1 if any stop sample is 0.
REQ-024 On the last stop sample the frame SHALL be pushed the next cycle as {ferr,perr,data}, errors included.
REQ-025 After last stop sample: ferr=0 -> IDLE; ferr=1 -> BREAK_WAIT, which returns to IDLE on first rx==1.
REQ-026 Push SHALL be accepted if level<FIFO_DEPTH or a pop occurs in the same cycle; otherwise frame dropped and overrun=1 for one cycle.
REQ-027 rdata/perr/ferr SHALL be valid whenever rvalid=1 and stable until popped.
REQ-028 Pop with rvalid=0 SHALL be ignored; level never underflows or exceeds FIFO_DEPTH.
REQ-029 Simultaneous push and pop SHALL leave level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-030 Latency: rvalid SHALL rise 2 cycles after the last stop-bit sample when FIFO was empty.

Reset
REQ-031 rst=1 SHALL force state IDLE, timer 0, synchronizer 3'b111, FIFO empty, level=0, rvalid=0, rdata=0, perr=0, ferr=0, overrun=0.
REQ-032 rst asserted mid-frame SHALL discard the partial frame and all FIFO content; reception restarts at the next falling edge after rst deasserts.

Verification (CLK_PER_HALF_BIT=4 unless stated)
REQ-033 8N1, send 0xA5 -> rvalid rises, rdata=0xA5, perr=0, ferr=0, level=1; pop -> level=0.
REQ-034 PARITY=2, send 0x07 with parity bit 0 -> rdata=0x07, perr=1; with parity bit 1 -> perr=0.
REQ-035 rxd low for 3 cycles then high -> start rejected, no push, state IDLE.
REQ-036 Stop bit 0 then rxd held low 40 cycles -> one entry with ferr=1, no further frames until rxd returns high.
REQ-037 FIFO_DEPTH=4, send 5 frames without pop -> level=4, overrun pulses once, entries 1..4 intact in order.
REQ-038 rst pulsed during DATA of frame 2 with frame 1 queued -> level=0, rvalid=0; next clean frame 0x3C received correctly.
